// File: rtl/xif_result_reorder_buffer.sv
// In-order result return for XIF-offloaded instructions: tracks issue, commit/kill and
// out-of-order completion per entry, and presents the oldest committed, completed result.
module xif_result_reorder_buffer #(
    parameter int DEPTH       = 4,
    parameter int X_ID_WIDTH  = 4,
    parameter int X_RFW_WIDTH = 32,
    parameter int XLEN        = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        issue_valid,
    output logic                        issue_ready,
    input  logic [X_ID_WIDTH-1:0]       issue_id,
    input  logic [4:0]                  issue_rd,
    input  logic                        issue_writeback,
    input  logic                        commit_valid,
    input  logic [X_ID_WIDTH-1:0]       commit_id,
    input  logic                        commit_kill,
    input  logic                        done_valid,
    input  logic [X_ID_WIDTH-1:0]       done_id,
    input  logic [X_RFW_WIDTH-1:0]      done_data,
    input  logic                        done_exc,
    input  logic [5:0]                  done_exccode,
    output logic                        result_valid,
    input  logic                        result_ready,
    output logic [X_ID_WIDTH-1:0]       result_id,
    output logic [X_RFW_WIDTH-1:0]      result_data,
    output logic [4:0]                  result_rd,
    output logic                        result_we,
    output logic                        result_exc,
    output logic [5:0]                  result_exccode,
    output logic [$clog2(DEPTH+1)-1:0]  outstanding,
    output logic                        empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    if (X_RFW_WIDTH != XLEN && X_RFW_WIDTH != 2 * XLEN) begin : g_bad_rfw
        $error("X_RFW_WIDTH must be XLEN or 2*XLEN");
    end

    logic [DEPTH-1:0]       valid_q, valid_d;
    logic [DEPTH-1:0]       cmt_q, cmt_d;
    logic [DEPTH-1:0]       kill_q, kill_d;
    logic [DEPTH-1:0]       done_q, done_d;
    logic [PW-1:0]          head_q, head_d;
    logic [PW-1:0]          tail_q, tail_d;
    logic [CW-1:0]          count_q, count_d;

    logic [X_ID_WIDTH-1:0]  id_q   [DEPTH];
    logic [4:0]             rd_q   [DEPTH];
    logic [X_RFW_WIDTH-1:0] data_q [DEPTH];
    logic [5:0]             code_q [DEPTH];
    logic [DEPTH-1:0]       wb_q;
    logic [DEPTH-1:0]       exc_q;

    logic [DEPTH-1:0]       cmt_hit;
    logic [DEPTH-1:0]       done_hit;
    logic                   alloc;
    logic                   alloc_cmt;
    logic                   kill_retire;
    logic                   retire;

    assign issue_ready = (count_q < DEPTH_C);
    assign alloc       = issue_valid & issue_ready;
    // A commit racing its own issue lands directly in the freshly written entry.
    assign alloc_cmt   = commit_valid & (commit_id == issue_id);

    // Already-committed entries ignore further commits so a presented result cannot be killed.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            cmt_hit[i]  = commit_valid & valid_q[i] & ~cmt_q[i] & (id_q[i] == commit_id);
            done_hit[i] = done_valid & valid_q[i] & ~(cmt_q[i] & kill_q[i])
                          & (id_q[i] == done_id);
        end
    end

    assign kill_retire  = valid_q[head_q] & cmt_q[head_q] & kill_q[head_q];
    assign result_valid = valid_q[head_q] & cmt_q[head_q] & ~kill_q[head_q] & done_q[head_q];
    assign retire       = kill_retire | (result_valid & result_ready);

    always_comb begin
        valid_d = valid_q;
        cmt_d   = cmt_q;
        kill_d  = kill_q;
        done_d  = done_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q + CW'(alloc) - CW'(retire);
        for (int i = 0; i < DEPTH; i++) begin
            if (cmt_hit[i]) begin
                cmt_d[i]  = 1'b1;
                kill_d[i] = commit_kill;
            end
            if (done_hit[i]) begin
                done_d[i] = 1'b1;
            end
        end
        if (retire) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PW'(1);
        end
        // Never collides with the retiring slot: tail == head with a valid head means full.
        if (alloc) begin
            valid_d[tail_q] = 1'b1;
            cmt_d[tail_q]   = alloc_cmt;
            kill_d[tail_q]  = alloc_cmt & commit_kill;
            done_d[tail_q]  = 1'b0;
            tail_d          = tail_q + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            cmt_q   <= '0;
            kill_q  <= '0;
            done_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            cmt_q   <= cmt_d;
            kill_q  <= kill_d;
            done_q  <= done_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload carries no reset; the done flag guards stale contents of a reused slot.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (done_hit[i]) begin
                data_q[i] <= done_data;
                exc_q[i]  <= done_exc;
                code_q[i] <= done_exccode;
            end
        end
        if (alloc) begin
            id_q[tail_q] <= issue_id;
            rd_q[tail_q] <= issue_rd;
            wb_q[tail_q] <= issue_writeback;
        end
    end

    assign result_id      = result_valid ? id_q[head_q]   : '0;
    assign result_data    = result_valid ? data_q[head_q] : '0;
    assign result_rd      = result_valid ? rd_q[head_q]   : '0;
    assign result_exc     = result_valid & exc_q[head_q];
    assign result_exccode = result_valid ? code_q[head_q] : '0;
    assign result_we      = result_valid & wb_q[head_q] & ~exc_q[head_q];

    assign outstanding = count_q;
    assign empty       = (count_q == '0);

endmodule
